// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_t;

  localparam int unsigned Oversample = 16;
  localparam int unsigned MidTick    = Oversample / 2 - 1;

endpackage

// File: rtl/uart_rx_if.sv
// Line-side inputs and parallel-word outputs of the UART receiver.
interface uart_rx_if #(
  parameter int unsigned DBIT = 8
);

  logic            tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  modport master (
    output tick, rx,
    input  dout, rx_done_tick, frame_err, busy
  );

  modport slave (
    input  tick, rx,
    output dout, rx_done_tick, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset value is programmable.
module sync_2ff #(
  parameter int unsigned     Width    = 1,
  parameter logic [Width-1:0] ResetVal = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= ResetVal;
      q      <= ResetVal;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB-first, one-cycle done strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  // Tick counter grows to 5 bits only when the stop phase outlasts one bit time.
  localparam int unsigned SW = (SB_TICK > Oversample) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] SMid     = SW'(MidTick);
  localparam logic [SW-1:0] SBitLast = SW'(Oversample - 1);
  localparam logic [SW-1:0] SStop    = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast    = NW'(DBIT - 1);

  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            rx_s;

  sync_2ff #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (bus.tick) begin
          if (s_q == SMid) begin
            if (!rx_s) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (bus.tick) begin
          if (s_q == SBitLast) begin
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            s_d     = '0;
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (bus.tick) begin
          if (s_q == SStop) begin
            state_d = StIdle;
            dout_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.frame_err    = ferr_q;
  assign bus.rx_done_tick = done_q;
  assign bus.busy         = (state_q != StIdle);

endmodule
